// File: rtl/divider_array_pipelined_pkg.sv
// Shared definitions for the pipelined restoring array divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Stage record at the default width. Modules that take a width parameter
  // declare the same field layout locally, sized by their own width.
  typedef struct packed {
    logic                         valid;
    logic                         dbz;
    logic [DIV_WIDTH_DEFAULT-1:0] a;
    logic [DIV_WIDTH_DEFAULT-1:0] b;
    logic [DIV_WIDTH_DEFAULT:0]   rem;
    logic [DIV_WIDTH_DEFAULT-1:0] q;
  } div_stage_t;

  // Flat bit count of a stage record: valid, dbz, a, b, rem (w+1), q.
  function automatic int stage_rec_width(input int w);
    return 2 + 4 * w + 1;
  endfunction

endpackage

// File: rtl/divider_array_pipelined_if.sv
// Operand/result bundle of the pipelined divider.
interface divider_array_pipelined_if
  import div_pkg::*;
#(
  parameter int width = DIV_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             out_valid;
  logic [width-1:0] q;
  logic [width-1:0] r;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b,
    input  out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, q, r, div_by_zero
  );

endinterface

// File: rtl/divider_array_pipelined_stage.sv
// One registered restoring-division step resolving quotient bit i.
module divider_stage
  import div_pkg::*;
#(
  parameter int width = DIV_WIDTH_DEFAULT,
  parameter int i     = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [stage_rec_width(width)-1:0]   rec_in,
  output logic [stage_rec_width(width)-1:0]   rec_out
);

  typedef struct packed {
    logic             valid;
    logic             dbz;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic [width:0]   rem;
    logic [width-1:0] q;
  } stage_t;

  stage_t           s_in;
  stage_t           s_out;
  logic [width:0]   p;
  logic [width:0]   b_ext;
  logic [width:0]   rem_next;
  logic [width-1:0] q_next;
  logic             unused_rem_msb;

  assign s_in    = rec_in;
  assign rec_out = s_out;

  // Remainder before the shift is always < b, so its top bit is never needed.
  assign unused_rem_msb = s_in.rem[width];

  // Shift in the next dividend bit and subtract the divisor if it fits.
  // With b == 0 the compare always succeeds, giving all-ones q and r == a.
  always_comb begin
    p        = {s_in.rem[width-1:0], s_in.a[i]};
    b_ext    = {1'b0, s_in.b};
    rem_next = p;
    q_next   = s_in.q;
    if (p >= b_ext) begin
      rem_next  = p - b_ext;
      q_next[i] = 1'b1;
    end else begin
      q_next[i] = 1'b0;
    end
  end

  // Data only moves with a valid slot, so bubbles leave the record untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out <= '0;
    end else begin
      s_out.valid <= s_in.valid;
      if (s_in.valid) begin
        s_out.dbz <= s_in.dbz;
        s_out.a   <= s_in.a;
        s_out.b   <= s_in.b;
        s_out.rem <= rem_next;
        s_out.q   <= q_next;
      end
    end
  end

endmodule

// File: rtl/divider_array_pipelined.sv
// Fully pipelined unsigned restoring divider: input register plus one
// stage per quotient bit, MSB first; latency width+1 edges, one op per clock.
module divider_array_pipelined
  import div_pkg::*;
#(
  parameter int width = DIV_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  divider_array_pipelined_if.slave   bus
);

  localparam int rec_w = stage_rec_width(width);

  typedef struct packed {
    logic             valid;
    logic             dbz;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic [width:0]   rem;
    logic [width-1:0] q;
  } stage_t;

  stage_t           s0;
  stage_t           fin;
  logic [rec_w-1:0] pipe [0:width];
  logic             unused_fin;

  // Input register: capture operands and flag a zero divisor up front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
    end else begin
      s0.valid <= bus.in_valid;
      if (bus.in_valid) begin
        s0.dbz <= (bus.b == '0);
        s0.a   <= bus.a;
        s0.b   <= bus.b;
        s0.rem <= '0;
        s0.q   <= '0;
      end
    end
  end

  assign pipe[0] = s0;

  for (genvar j = 1; j <= width; j++) begin : g_stage
    divider_stage #(
      .width (width),
      .i     (width - j)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .rec_in  (pipe[j-1]),
      .rec_out (pipe[j])
    );
  end

  assign fin = pipe[width];

  // Operand copies and remainder MSB are spent by the time the last stage fires.
  assign unused_fin = ^{fin.a, fin.b, fin.rem[width]};

  assign bus.out_valid   = fin.valid;
  assign bus.q           = fin.q;
  assign bus.r           = fin.rem[width-1:0];
  assign bus.div_by_zero = fin.dbz;

endmodule
